// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: decoder classes, ALU control codes,
// RV32M op selector and the multi-cycle sequencer states.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  // Values equal the instruction funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIN  = 2'b11
  } md_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes,
// sign fix-up in the final step. done_c/res_c are valid while in FIN.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  md_op_e          mop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            idle,
  output logic            done_c,
  output logic [XLEN-1:0] res_c
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_e       state, state_nx;
  md_op_e          op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_q, b_q, acc, lo;
  logic            neg_q;

  logic            sgn_a, sgn_b;
  logic [XLEN:0]   sum, rs, diff;
  logic [XLEN-1:0] acc_nx, lo_nx, quo, rem;
  logic [2*XLEN-1:0] prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_PREP;
      ST_PREP: state_nx = ST_CALC;
      ST_CALC: if (cnt == '0) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush && state != ST_IDLE) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      idle <= 1'b1;
    end else begin
      busy <= (state_nx != ST_IDLE);
      idle <= (state_nx == ST_IDLE);
    end
  end

  // Operand signs only matter for the signed flavours
  always_comb begin
    sgn_a = a_q[XLEN-1] && (op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn_b = b_q[XLEN-1] && (op_q inside {MD_MULH, MD_DIV, MD_REM});
  end

  // One radix-2 step: acc is the high product word / partial remainder
  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, b_q} : '0);
    rs   = {acc, lo[XLEN-1]};
    diff = rs - {1'b0, b_q};
    if (op_q[2]) begin
      acc_nx = diff[XLEN] ? {acc[XLEN-2:0], lo[XLEN-1]} : diff[XLEN-1:0];
      lo_nx  = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_nx = sum[XLEN:1];
      lo_nx  = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= MD_MUL;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      lo    <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_q <= mop;
          a_q  <= a;
          b_q  <= b;
        end
        ST_PREP: begin
          lo    <= sgn_a ? -a_q : a_q;
          b_q   <= sgn_b ? -b_q : b_q;
          acc   <= '0;
          cnt   <= CW'(XLEN - 1);
          neg_q <= (op_q inside {MD_REM, MD_REMU}) ? sgn_a : (sgn_a ^ sgn_b);
        end
        ST_CALC: begin
          acc <= acc_nx;
          lo  <= lo_nx;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod   = neg_q ? -{acc, lo} : {acc, lo};
    quo    = neg_q ? -lo : lo;
    rem    = neg_q ? -acc : acc;
    done_c = (state == ST_FIN);
    case (op_q)
      MD_MUL:                      res_c = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_c = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             res_c = quo;
      default:                     res_c = rem;
    endcase
  end

endmodule

// File: rtl/alu_exec_md.sv
// EX-stage ALU: decode to a 4-bit control, single-cycle RV32I ops and divide
// corner cases, with RV32M handed to the iterative engine behind a handshake.
module alu_exec_md
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_ctrl_e       ctrl;
  md_op_e          mop;
  logic            is_m, is_special, ovf, div0, accept, single, start;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, spec_res, one_res, md_res;
  logic            md_done;
  logic            unused_op;

  assign unused_op = ^{op[6], op[4:0]};

  always_comb begin
    ctrl = ALU_ADD;
    is_m = 1'b0;
    mop  = md_op_e'(funct3);
    case (ALUOp)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default:        ctrl = ALU_SUB;
        endcase
      end
      ALUOP_LUI: ctrl = ALU_PASSB;
      default: begin
        is_m = EN_M && op[5] && (funct7 == FUNCT7_MULDIV);
        case (funct3)
          3'b000:  ctrl = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  assign shamt = srcB[SHW-1:0];

  always_comb begin
    case (ctrl)
      ALU_ADD:   alu_res = srcA + srcB;
      ALU_SUB:   alu_res = srcA - srcB;
      ALU_AND:   alu_res = srcA & srcB;
      ALU_OR:    alu_res = srcA | srcB;
      ALU_XOR:   alu_res = srcA ^ srcB;
      ALU_SLT:   alu_res = XLEN'($signed(srcA) < $signed(srcB));
      ALU_SLTU:  alu_res = XLEN'(srcA < srcB);
      ALU_SLL:   alu_res = srcA << shamt;
      ALU_SRL:   alu_res = srcA >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(srcA) >>> shamt);
      ALU_PASSB: alu_res = srcB;
      default:   alu_res = '0;
    endcase
  end

  // Divide by zero and signed overflow finish without iterating
  always_comb begin
    div0       = (srcB == '0);
    ovf        = (mop == MD_DIV || mop == MD_REM) &&
                 (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (&srcB);
    is_special = funct3[2] && (div0 || ovf);
    if (div0) spec_res = funct3[1] ? srcA : '1;
    else      spec_res = funct3[1] ? '0 : srcA;
    one_res    = is_m ? spec_res : alu_res;
  end

  assign accept = in_valid && in_ready && !flush;
  assign single = accept && (!is_m || is_special);
  assign start  = accept && is_m && !is_special;

  alu_md_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (start),
    .mop    (mop),
    .a      (srcA),
    .b      (srcB),
    .busy   (busy),
    .idle   (in_ready),
    .done_c (md_done),
    .res_c  (md_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (single) begin
        out_valid <= 1'b1;
        result    <= one_res;
        zero      <= (one_res == '0);
      end else if (md_done && !flush) begin
        out_valid <= 1'b1;
        result    <= md_res;
        zero      <= (md_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_md.sv
// Bench for alu_exec_md: directed cases plus random ops against an
// arithmetic reference model, including flush and mid-operation reset.
module tb_alu_exec_md;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7, op;
  logic [XLEN-1:0] srcA, srcB, result;
  logic            out_valid, zero, busy;

  int n_chk  = 0;
  int n_pass = 0;

  alu_exec_md #(.XLEN(XLEN), .EN_M(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .op(op),
    .srcA(srcA), .srcB(srcB), .out_valid(out_valid), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic; busy_cyc is PREP+CALC+FIN for iterative ops
  function automatic logic [31:0] model(input logic [1:0] aop, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [6:0] opc,
                                        input logic [31:0] a, input logic [31:0] b,
                                        output int busy_cyc);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    busy_cyc = 0;
    case (aop)
      2'b00: return a + b;
      2'b01: begin
        if (f3[2:1] == 2'b10) return {31'd0, $signed(a) < $signed(b)};
        if (f3[2:1] == 2'b11) return {31'd0, a < b};
        return a - b;
      end
      2'b11: return b;
      default: begin
        if (opc[5] && f7 == 7'h01) begin
          if (f3[2] && b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
          if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f3[1] ? 32'd0 : a;
          busy_cyc = XLEN + 2;
          case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return 32'(sa / sb);
            3'd5: return 32'(ua / ub);
            3'd6: return 32'(sa % sb);
            default: return 32'(ua % ub);
          endcase
        end
        case (f3)
          3'd0: return (opc[5] && f7[5]) ? a - b : a + b;
          3'd1: return a << b[4:0];
          3'd2: return {31'd0, $signed(a) < $signed(b)};
          3'd3: return {31'd0, a < b};
          3'd4: return a ^ b;
          3'd5: return f7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    ALUOp = aop; funct3 = f3; funct7 = f7; op = opc; srcA = a; srcB = b;
  endtask

  task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] opc,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int exp_busy, low_cnt, busy_cnt, cyc;
    exp = model(aop, f3, f7, opc, a, b, exp_busy);
    @(negedge clk);
    drive(aop, f3, f7, opc, a, b);
    in_valid = 1'b1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive(2'($urandom), 3'($urandom), 7'($urandom), 7'($urandom), $urandom, $urandom);
    low_cnt = 0; busy_cnt = 0; cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (!in_ready) low_cnt++;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(exp));
    chk({tag, " zero"}, 64'(zero), 64'(exp == 32'd0));
    chk({tag, " in_ready low cycles"}, 64'(low_cnt), 64'(exp_busy));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'(out_valid), 64'd0);
    chk({tag, " hold"}, 64'(result), 64'(exp));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " result"}, 64'(result), 64'd0);
    chk({tag, " zero"}, 64'(zero), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  int seen;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    drive(2'b00, 3'd0, 7'd0, 7'h33, 32'd0, 32'd0);
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst = 1'b1;

    run_op("add",    2'b10, 3'b000, 7'h00, 7'h33, 32'd5, 32'd7);
    run_op("beq",    2'b01, 3'b000, 7'h00, 7'h63, 32'h1234, 32'h1234);
    run_op("bltu",   2'b01, 3'b110, 7'h00, 7'h63, 32'd1, 32'hFFFF_FFFF);
    run_op("sra",    2'b10, 3'b101, 7'h20, 7'h33, 32'h8000_0000, 32'd4);
    run_op("srl",    2'b10, 3'b101, 7'h00, 7'h33, 32'h8000_0000, 32'd4);
    run_op("lui",    2'b11, 3'b000, 7'h00, 7'h37, 32'd9, 32'hABCD_E000);
    run_op("mulh",   2'b10, 3'b001, 7'h01, 7'h33, 32'hFFFF_FFFF, 32'd2);
    run_op("mul",    2'b10, 3'b000, 7'h01, 7'h33, 32'hFFFF_FFFF, 32'd2);
    run_op("div",    2'b10, 3'b100, 7'h01, 7'h33, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",    2'b10, 3'b110, 7'h01, 7'h33, 32'hFFFF_FFF9, 32'd2);
    run_op("div0",   2'b10, 3'b100, 7'h01, 7'h33, 32'd100, 32'd0);
    run_op("remu0",  2'b10, 3'b111, 7'h01, 7'h33, 32'd100, 32'd0);
    run_op("divovf", 2'b10, 3'b100, 7'h01, 7'h33, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 2'b10, 3'b110, 7'h01, 7'h33, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mulhsu", 2'b10, 3'b010, 7'h01, 7'h33, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("addi_m", 2'b10, 3'b000, 7'h01, 7'h13, 32'd3, 32'd4);

    // Flush during an iterative DIVU
    @(negedge clk);
    drive(2'b10, 3'b101, 7'h01, 7'h33, 32'd1000, 32'd7);
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("divu busy before flush", 64'(busy), 64'd1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush no out_valid", 64'(seen), 64'd0);
    run_op("add after flush", 2'b00, 3'b000, 7'h00, 7'h03, 32'd40, 32'd2);

    // Flush in the accept cycle, single-cycle and iterative
    @(negedge clk);
    drive(2'b00, 3'b000, 7'h00, 7'h03, 32'd1, 32'd1);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush accept out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    drive(2'b10, 3'b000, 7'h01, 7'h33, 32'd3, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush accept mul busy", 64'(busy), 64'd0);
    chk("flush accept mul in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a MUL
    @(negedge clk);
    drive(2'b10, 3'b000, 7'h01, 7'h33, 32'd12345, 32'd678);
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 check_reset_vals("mid-mul reset");
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("post reset no out_valid", 64'(seen), 64'd0);

    for (int i = 0; i < 150; i++) begin
      logic [6:0] f7r;
      case ($urandom_range(0, 3))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        2: f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             f7r, ($urandom_range(0, 3) != 0) ? 7'h33 : 7'h13, rnd_operand(), rnd_operand());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
